// File: rtl/stack_arbiter_if.sv
// stack_arbiter_if: bundles the two client request buses, read-back bus and stack command/status bus.
//   A_/B_Push, A_/B_Pop, A_/B_Data : client requests (master -> slave)
//   A_/B_Gnt, A_/B_Err             : client completion / reject pulses (slave -> master)
//   Rd_Data, Rd_Id, Rd_Valid       : popped value, its owner, valid pulse (slave -> master)
//   Stk_Push, Stk_Pop, Stk_Data_In : stack command (slave -> master)
//   Stk_Data_Out, Stk_Full, Stk_Empty : stack read data and status (master -> slave)
interface stack_arbiter_if #(parameter int DW = 4);
   logic          A_Push, A_Pop, A_Gnt, A_Err;
   logic [DW-1:0] A_Data;
   logic          B_Push, B_Pop, B_Gnt, B_Err;
   logic [DW-1:0] B_Data;
   logic [DW-1:0] Rd_Data;
   logic          Rd_Id, Rd_Valid;
   logic          Stk_Push, Stk_Pop;
   logic [DW-1:0] Stk_Data_In;
   logic [DW-1:0] Stk_Data_Out;
   logic          Stk_Full, Stk_Empty;
   modport slave (
      input  A_Push, A_Pop, A_Data, B_Push, B_Pop, B_Data, Stk_Data_Out, Stk_Full, Stk_Empty,
      output A_Gnt, A_Err, B_Gnt, B_Err, Rd_Data, Rd_Id, Rd_Valid, Stk_Push, Stk_Pop, Stk_Data_In
   );
   modport master (
      output A_Push, A_Pop, A_Data, B_Push, B_Pop, B_Data, Stk_Data_Out, Stk_Full, Stk_Empty,
      input  A_Gnt, A_Err, B_Gnt, B_Err, Rd_Data, Rd_Id, Rd_Valid, Stk_Push, Stk_Pop, Stk_Data_In
   );
endinterface

// File: rtl/stack_arbiter.sv
// stack_arbiter: arbitrates two clients onto a single stack, one transaction in flight at a time.
//   Clk  : single clock, rising edge
//   RstN : synchronous reset, active-high despite the name
//   bus  : stack_arbiter_if.slave (client requests/pulses, read-back, stack command/status)
//   DW   : data width; must match the DW of the connected interface
// Build option: define STACK_ARB_FIXED_PRIO_EN to make client A win every tie;
// otherwise ties are resolved round-robin against the last winner.
module stack_arbiter #(parameter int DW = 4) (
   input  logic           Clk,
   input  logic           RstN,
   stack_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, DONE} state_t;
   state_t        state, state_nxt;
   logic          a_req, b_req, any_req, sel_b;
   logic          w_push, w_pop, w_err, go;
   logic [DW-1:0] w_data;
   logic          win_id, win_pop, win_err;
   logic          stk_push, stk_pop, rd_id;
   logic [DW-1:0] stk_data_in, rd_data;
`ifndef STACK_ARB_FIXED_PRIO_EN
   logic          last_b;
`endif
   assign a_req   = bus.A_Push | bus.A_Pop;
   assign b_req   = bus.B_Push | bus.B_Pop;
   assign any_req = a_req | b_req;
`ifdef STACK_ARB_FIXED_PRIO_EN
   assign sel_b = b_req & ~a_req;
`else
   // on a tie, B wins only if A was the last client served
   assign sel_b = b_req & (~a_req | ~last_b);
`endif
   assign w_push = sel_b ? bus.B_Push : bus.A_Push;
   assign w_pop  = sel_b ? bus.B_Pop  : bus.A_Pop;
   assign w_data = sel_b ? bus.B_Data : bus.A_Data;
   // both ops at once, push into full or pop from empty are rejected without touching the stack
   assign w_err  = (w_push & w_pop) | (w_push & bus.Stk_Full) | (w_pop & bus.Stk_Empty);
   assign go     = (state == IDLE) & any_req & ~w_err;
   always_ff @(posedge Clk) begin
      if (RstN) state <= IDLE;
      else      state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = !any_req ? IDLE : (w_err ? DONE : ISSUE);
         ISSUE:   state_nxt = win_pop ? RD_WAIT : DONE;
         RD_WAIT: state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge Clk) begin
      if (RstN) begin
         win_id      <= 1'b0;
         win_pop     <= 1'b0;
         win_err     <= 1'b0;
         stk_push    <= 1'b0;
         stk_pop     <= 1'b0;
         stk_data_in <= '0;
         rd_data     <= '0;
         rd_id       <= 1'b0;
`ifndef STACK_ARB_FIXED_PRIO_EN
         last_b      <= 1'b1;
`endif
      end else begin
         // command pulses are registered so they line up exactly with the ISSUE cycle
         stk_push <= go & w_push;
         stk_pop  <= go & w_pop;
         if (state == IDLE && any_req) begin
            win_id      <= sel_b;
            win_pop     <= w_pop;
            win_err     <= w_err;
            stk_data_in <= w_data;
         end
         if (state == RD_WAIT) begin
            rd_data <= bus.Stk_Data_Out;
            rd_id   <= win_id;
         end
`ifndef STACK_ARB_FIXED_PRIO_EN
         if (state == DONE) last_b <= win_id;
`endif
      end
   end
   always_comb begin
      bus.A_Gnt    = (state == DONE) & ~win_err & ~win_id;
      bus.A_Err    = (state == DONE) &  win_err & ~win_id;
      bus.B_Gnt    = (state == DONE) & ~win_err &  win_id;
      bus.B_Err    = (state == DONE) &  win_err &  win_id;
      bus.Rd_Valid = (state == DONE) & ~win_err &  win_pop;
   end
   assign bus.Stk_Push    = stk_push;
   assign bus.Stk_Pop     = stk_pop;
   assign bus.Stk_Data_In = stk_data_in;
   assign bus.Rd_Data     = rd_data;
   assign bus.Rd_Id       = rd_id;
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed self-checking bench for stack_arbiter.
module tb_stack_arbiter;
   logic Clk = 1'b0;
   logic RstN = 1'b1;
   int   n_pass = 0;
   int   n_chk = 0;
`ifdef STACK_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif
   stack_arbiter_if #(.DW(4)) bus();
   stack_arbiter #(.DW(4)) dut (.Clk(Clk), .RstN(RstN), .bus(bus));
   always #5 Clk = ~Clk;
   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   task automatic tick;
      @(posedge Clk);
      #1;
   endtask
   initial begin
      bus.A_Push = 1'b0; bus.A_Pop = 1'b0; bus.A_Data = 4'h0;
      bus.B_Push = 1'b0; bus.B_Pop = 1'b0; bus.B_Data = 4'h0;
      bus.Stk_Data_Out = 4'h0; bus.Stk_Full = 1'b0; bus.Stk_Empty = 1'b1;
      tick; tick;
      RstN = 1'b0;
      check("rst_a_gnt",   8'(bus.A_Gnt), 8'h0);
      check("rst_a_err",   8'(bus.A_Err), 8'h0);
      check("rst_b_gnt",   8'(bus.B_Gnt), 8'h0);
      check("rst_b_err",   8'(bus.B_Err), 8'h0);
      check("rst_rd_vld",  8'(bus.Rd_Valid), 8'h0);
      check("rst_push",    8'(bus.Stk_Push), 8'h0);
      check("rst_pop",     8'(bus.Stk_Pop), 8'h0);
      check("rst_rd_data", 8'(bus.Rd_Data), 8'h0);
      check("rst_rd_id",   8'(bus.Rd_Id), 8'h0);
      check("rst_din",     8'(bus.Stk_Data_In), 8'h0);
      // push 1111 into an empty stack
      bus.A_Push = 1'b1; bus.A_Data = 4'hF;
      tick;
      check("p1_push",  8'(bus.Stk_Push), 8'h1);
      check("p1_din",   8'(bus.Stk_Data_In), 8'hF);
      check("p1_early", 8'(bus.A_Gnt), 8'h0);
      tick;
      check("p1_gnt",   8'(bus.A_Gnt), 8'h1);
      check("p1_push0", 8'(bus.Stk_Push), 8'h0);
      bus.A_Push = 1'b0;
      tick;
      // fresh reset so the first tie goes to A, then A re-requests immediately
      RstN = 1'b1;
      tick;
      RstN = 1'b0;
      bus.A_Push = 1'b1; bus.A_Data = 4'hD;
      bus.B_Push = 1'b1; bus.B_Data = 4'h6;
      tick;
      check("tie1_din", 8'(bus.Stk_Data_In), 8'hD);
      check("tie1_push", 8'(bus.Stk_Push), 8'h1);
      tick;
      check("tie1_a_gnt", 8'(bus.A_Gnt), 8'h1);
      check("tie1_b_gnt", 8'(bus.B_Gnt), 8'h0);
      bus.A_Data = 4'h3;
      tick;
      tick;
      check("tie2_din", 8'(bus.Stk_Data_In), 8'(FIXED ? 4'h3 : 4'h6));
      tick;
      check("tie2_a_gnt", 8'(bus.A_Gnt), 8'(FIXED));
      check("tie2_b_gnt", 8'(bus.B_Gnt), 8'(!FIXED));
      if (FIXED) bus.A_Push = 1'b0;
      else       bus.B_Push = 1'b0;
      tick;
      tick;
      check("tie3_din", 8'(bus.Stk_Data_In), 8'(FIXED ? 4'h6 : 4'h3));
      tick;
      check("tie3_a_gnt", 8'(bus.A_Gnt), 8'(!FIXED));
      check("tie3_b_gnt", 8'(bus.B_Gnt), 8'(FIXED));
      bus.A_Push = 1'b0; bus.B_Push = 1'b0;
      tick;
      // B pops 1101
      bus.Stk_Empty = 1'b0; bus.Stk_Data_Out = 4'hD; bus.B_Pop = 1'b1;
      tick;
      check("pop_cmd",  8'(bus.Stk_Pop), 8'h1);
      check("pop_nopush", 8'(bus.Stk_Push), 8'h0);
      tick;
      check("pop_wait_vld", 8'(bus.Rd_Valid), 8'h0);
      check("pop_wait_gnt", 8'(bus.B_Gnt), 8'h0);
      tick;
      check("pop_vld",  8'(bus.Rd_Valid), 8'h1);
      check("pop_data", 8'(bus.Rd_Data), 8'hD);
      check("pop_id",   8'(bus.Rd_Id), 8'h1);
      check("pop_gnt",  8'(bus.B_Gnt), 8'h1);
      bus.B_Pop = 1'b0; bus.Stk_Data_Out = 4'h0;
      tick;
      // push while full, pop while empty
      bus.Stk_Full = 1'b1; bus.A_Push = 1'b1; bus.A_Data = 4'h9;
      tick;
      check("full_err",  8'(bus.A_Err), 8'h1);
      check("full_gnt",  8'(bus.A_Gnt), 8'h0);
      check("full_push", 8'(bus.Stk_Push), 8'h0);
      bus.A_Push = 1'b0; bus.Stk_Full = 1'b0;
      tick;
      bus.Stk_Empty = 1'b1; bus.B_Pop = 1'b1;
      tick;
      check("empty_err", 8'(bus.B_Err), 8'h1);
      check("empty_pop", 8'(bus.Stk_Pop), 8'h0);
      check("empty_vld", 8'(bus.Rd_Valid), 8'h0);
      check("rd_hold",   8'(bus.Rd_Data), 8'hD);
      bus.B_Pop = 1'b0;
      tick;
      // push and pop together
      bus.Stk_Empty = 1'b0; bus.A_Push = 1'b1; bus.A_Pop = 1'b1; bus.A_Data = 4'h0;
      tick;
      check("both_err",  8'(bus.A_Err), 8'h1);
      check("both_push", 8'(bus.Stk_Push), 8'h0);
      check("both_pop",  8'(bus.Stk_Pop), 8'h0);
      check("both_vld",  8'(bus.Rd_Valid), 8'h0);
      bus.A_Push = 1'b0; bus.A_Pop = 1'b0;
      tick;
      // reset lands during RD_WAIT
      bus.Stk_Data_Out = 4'h5; bus.A_Pop = 1'b1;
      tick;
      check("abort_pop", 8'(bus.Stk_Pop), 8'h1);
      tick;
      RstN = 1'b1;
      tick;
      check("abort_vld",  8'(bus.Rd_Valid), 8'h0);
      check("abort_gnt",  8'(bus.A_Gnt), 8'h0);
      check("abort_data", 8'(bus.Rd_Data), 8'h0);
      RstN = 1'b0;
      bus.A_Pop = 1'b0; bus.A_Push = 1'b1; bus.A_Data = 4'h7;
      tick;
      check("post_push", 8'(bus.Stk_Push), 8'h1);
      check("post_din",  8'(bus.Stk_Data_In), 8'h7);
      tick;
      check("post_gnt",  8'(bus.A_Gnt), 8'h1);
      bus.A_Push = 1'b0;
      tick;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
